// File: rtl/div_24x12_seq_if.sv
// div_24x12_seq_if: valid/ready request and response bundle for the sequential divider
interface div_24x12_seq_if #(parameter int WIDTH = 12);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_24x12_seq.sv
// div_24x12_seq: radix-2 restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
module div_24x12_seq #(
    parameter int WIDTH = 12
) (
    input logic             clk,
    input logic             rst_n,
    div_24x12_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;
    logic             dbz_r, ovf_r;
    logic             accept, first, last, zero, ovf_cond, ge;
    logic [WIDTH:0]   t;

    assign accept   = state == IDLE && bus.in_valid;
    assign first    = cnt == '0;
    assign last     = cnt == CW'(WIDTH);
    assign zero     = dvs_r == '0;
    assign ovf_cond = rem_r >= dvs_r;
    assign t        = {rem_r, q_r[WIDTH-1]};
    assign ge       = t >= {1'b0, dvs_r};

    assign bus.quotient    = q_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

    // state register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // next state and handshake outputs; the first RUN cycle classifies the operands
    always_comb begin
        state_next    = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        unique case (state)
            IDLE:    state_next = bus.in_valid ? RUN : IDLE;
            RUN:     state_next = (first && (zero || ovf_cond)) || last ? DONE : RUN;
            DONE:    state_next = bus.out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // datapath: q_r shifts dividend bits out at the top and quotient bits in at the bottom
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_r <= '0;
            q_r   <= '0;
            dvs_r <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            rem_r <= bus.dividend[2*WIDTH-1:WIDTH];
            q_r   <= bus.dividend[WIDTH-1:0];
            dvs_r <= bus.divisor;
            cnt   <= '0;
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (first) begin
                if (zero) begin
                    dbz_r <= 1'b1;
                    q_r   <= '1;
                    rem_r <= q_r;
                end else if (ovf_cond) begin
                    ovf_r <= 1'b1;
                    q_r   <= '1;
                    rem_r <= '0;
                end
            end else begin
                q_r   <= {q_r[WIDTH-2:0], ge};
                rem_r <= WIDTH'(ge ? t - {1'b0, dvs_r} : t);
            end
        end
    end
endmodule

// File: tb/tb_div_24x12_seq.sv
// tb_div_24x12_seq: directed and invariant checks for the sequential divider
module tb_div_24x12_seq;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat;

    always #5 clk = ~clk;

    div_24x12_seq_if #(.WIDTH(W)) bus ();
    div_24x12_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [23:0] a, input logic [11:0] b);
        int k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [11:0] eq, input logic [11:0] er,
                             input logic ez, input logic eo, input int el);
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(ez));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
    endtask

    task automatic run_op(input string tag, input logic [23:0] a, input logic [11:0] b,
                          input logic [11:0] eq, input logic [11:0] er,
                          input logic ez, input logic eo, input int el);
        start_op(a, b);
        wait_done();
        check_out(tag, eq, er, ez, eo, el);
        release_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [11:0] b;
        logic        ez, eo;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_flags", 32'({bus.div_by_zero, bus.overflow}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1_1716_12", 24'd1716, 12'd12, 12'd143, 12'd0, 1'b0, 1'b0, 13);
        run_op("t2_sq4095", 24'd16769025, 12'd4095, 12'd4095, 12'd0, 1'b0, 1'b0, 13);
        run_op("t2_1000_7", 24'd1000, 12'd7, 12'd142, 12'd6, 1'b0, 1'b0, 13);
        run_op("t3_dbz", 24'h000123, 12'd0, 12'hFFF, 12'h123, 1'b1, 1'b0, 1);
        run_op("t4_ovf", 24'd4096, 12'd1, 12'hFFF, 12'd0, 1'b0, 1'b1, 1);
        run_op("t4_4095_1", 24'd4095, 12'd1, 12'd4095, 12'd0, 1'b0, 1'b0, 13);

        start_op(24'd1716, 12'd12);
        wait_done();
        check_out("t5_first", 12'd143, 12'd0, 1'b0, 1'b0, 13);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 24'd5;
            bus.divisor  = 12'd1;
            @(posedge clk);
            @(negedge clk);
            chk("t5_hold_quotient", 32'(bus.quotient), 32'd143);
            chk("t5_hold_remainder", 32'(bus.remainder), 32'd0);
            chk("t5_hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_out();
        run_op("t5_next", 24'd1000, 12'd7, 12'd142, 12'd6, 1'b0, 1'b0, 13);

        start_op(24'd1716, 12'd12);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_quotient", 32'(bus.quotient), 32'd0);
        repeat (15) @(negedge clk);
        chk("t6_no_output", 32'(bus.out_valid), 32'd0);
        run_op("t6_2000_9", 24'd2000, 12'd9, 12'd222, 12'd2, 1'b0, 1'b0, 13);

        for (int i = 0; i < 300; i++) begin
            b = 12'($urandom);
            a = 24'($urandom);
            if (i % 50 == 0)
                b = 12'd0;
            else if (i % 3 == 0 && b != 0)
                a = 24'($urandom_range(0, 32'(b) * 4096 - 1));
            ez = b == 0;
            eo = !ez && a[23:12] >= b;
            start_op(a, b);
            wait_done();
            chk("sw_latency", 32'(lat), (ez || eo) ? 32'd1 : 32'd13);
            chk("sw_div_by_zero", 32'(bus.div_by_zero), 32'(ez));
            chk("sw_overflow", 32'(bus.overflow), 32'(eo));
            if (ez || eo) begin
                chk("sw_sat_quotient", 32'(bus.quotient), 32'hFFF);
                chk("sw_sat_remainder", 32'(bus.remainder), ez ? 32'(a[11:0]) : 32'd0);
            end else begin
                chk("sw_inv_product", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
                chk("sw_inv_rem_lt", 32'(bus.remainder < b), 32'd1);
            end
            release_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
